// File: rtl/commit_ctrl_pkg.sv
// Shared commit-path types: ROB entry layout, store size, zero-register id.
// Imported by the commit controller, its interface and the pipeline top.
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

package commit_ctrl_pkg;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } MEM_SIZE;

  typedef struct packed {
    logic        valid;
    logic [31:0] value;
    logic [4:0]  dest_reg;
    logic [31:0] dest_addr;
    logic        wr_mem;
    MEM_SIZE     mem_size;
    logic        halt;
  } ROB_ENTRY;

endpackage

// File: rtl/commit_ctrl_if.sv
// Commit-side bundle: ROB head in, regfile write and store request out.
// master = commit controller, slave = ROB / regfile / memory side.
interface commit_ctrl_if;
  import commit_ctrl_pkg::*;

  ROB_ENTRY    head_entry;
  logic        head_ready;
  logic        mem_ready;
  logic        mem_ack;
  logic        rob_retire;
  logic        reg_wr_en;
  logic [4:0]  reg_wr_idx;
  logic [31:0] reg_wr_data;
  logic        st_req_valid;
  logic [31:0] st_req_addr;
  logic [31:0] st_req_data;
  MEM_SIZE     st_req_size;

  modport master (
    input  head_entry, head_ready,
    input  mem_ready, mem_ack,
    output rob_retire,
    output reg_wr_en, reg_wr_idx, reg_wr_data,
    output st_req_valid, st_req_addr,
    output st_req_data, st_req_size
  );

  modport slave (
    output head_entry, head_ready,
    output mem_ready, mem_ack,
    input  rob_retire,
    input  reg_wr_en, reg_wr_idx, reg_wr_data,
    input  st_req_valid, st_req_addr,
    input  st_req_data, st_req_size
  );

endinterface

// File: rtl/commit_ctrl.sv
// In-order commit: retires ALU ops in zero cycles, drains stores through
// a request/ack handshake with a timeout, and parks on halt or mem error.
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clock,
  input  logic         reset,
  commit_ctrl_if.master bus,
  output logic         halted,
  output logic         mem_error,
  output logic [31:0]  retire_count
);

  typedef enum logic [2:0] {
    IDLE, ST_REQ, ST_WAIT, HALTED, ERROR
  } state_t;

  state_t      st, nxt;
  logic [31:0] tmr;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  MEM_SIZE     cap_size;
  logic        retire;
  logic        wr_en;
  logic        req;
  logic        ld;
  logic        expired;
  logic        head_go;

  assign head_go = bus.head_entry.valid && bus.head_ready;
  // last permitted cycle of the store window
  assign expired = (tmr == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    nxt    = st;
    retire = 1'b0;
    wr_en  = 1'b0;
    req    = 1'b0;
    ld     = 1'b0;
    if (reset) begin
      nxt = IDLE;
    end else begin
      unique case (st)
        IDLE: begin
          if (head_go) begin
            if (bus.head_entry.halt) begin
              retire = 1'b1;
              nxt    = HALTED;
            end else if (bus.head_entry.wr_mem) begin
              ld  = 1'b1;
              nxt = ST_REQ;
            end else begin
              retire = 1'b1;
              wr_en  = (bus.head_entry.dest_reg != `ZERO_REG);
            end
          end
        end
        ST_REQ: begin
          req = 1'b1;
          if (bus.mem_ready && bus.mem_ack) begin
            retire = 1'b1;
            nxt    = IDLE;
          end else if (expired) begin
            nxt = ERROR;
          end else if (bus.mem_ready) begin
            nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.mem_ack) begin
            retire = 1'b1;
            nxt    = IDLE;
          end else if (expired) begin
            nxt = ERROR;
          end
        end
        HALTED:  nxt = HALTED;
        ERROR:   nxt = ERROR;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st           <= IDLE;
      tmr          <= '0;
      cap_addr     <= '0;
      cap_data     <= '0;
      cap_size     <= BYTE;
      retire_count <= '0;
    end else begin
      st <= nxt;
      if (ld) begin
        cap_addr <= bus.head_entry.dest_addr;
        cap_data <= bus.head_entry.value;
        cap_size <= bus.head_entry.mem_size;
        tmr      <= '0;
      end else if (st == ST_REQ || st == ST_WAIT) begin
        tmr <= tmr + 32'd1;
      end
      if (retire) retire_count <= retire_count + 32'd1;
    end
  end

  assign bus.rob_retire   = retire;
  assign bus.reg_wr_en    = wr_en;
  assign bus.reg_wr_idx   = wr_en ? bus.head_entry.dest_reg : 5'd0;
  assign bus.reg_wr_data  = wr_en ? bus.head_entry.value : 32'd0;
  assign bus.st_req_valid = req;
  assign bus.st_req_addr  = cap_addr;
  assign bus.st_req_data  = cap_data;
  assign bus.st_req_size  = cap_size;
  assign halted           = (st == HALTED);
  assign mem_error        = (st == ERROR);

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed and random commit traffic against a behavioural model of
// retirement, store draining, timeout, halt and reset.
module tb_commit_ctrl;
  import commit_ctrl_pkg::*;

  localparam int TMO = 8;

  logic        clock;
  logic        reset;
  logic        halted;
  logic        mem_error;
  logic [31:0] retire_count;

  commit_ctrl_if bus ();

  commit_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.master),
    .halted       (halted),
    .mem_error    (mem_error),
    .retire_count (retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // reference model: plain booleans and a wait counter
  bit          m_halted = 0;
  bit          m_error  = 0;
  bit          m_pend   = 0;
  bit          m_acc    = 0;
  int          m_wait   = 0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_data   = '0;
  logic [1:0]  m_size   = '0;
  logic [31:0] m_count  = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ROB_ENTRY alu(logic [4:0] d, logic [31:0] v);
    ROB_ENTRY e;
    e = '0;
    e.valid = 1'b1;
    e.dest_reg = d;
    e.value = v;
    e.dest_addr = $urandom;
    return e;
  endfunction

  function automatic ROB_ENTRY sto(logic [31:0] a, logic [31:0] v,
                                   MEM_SIZE s);
    ROB_ENTRY e;
    e = '0;
    e.valid = 1'b1;
    e.wr_mem = 1'b1;
    e.dest_addr = a;
    e.value = v;
    e.mem_size = s;
    e.dest_reg = 5'($urandom);
    return e;
  endfunction

  function automatic ROB_ENTRY hlt();
    ROB_ENTRY e;
    e = alu(5'd3, 32'h5a5a);
    e.halt = 1'b1;
    return e;
  endfunction

  function automatic ROB_ENTRY rnd();
    ROB_ENTRY e;
    e.valid     = ($urandom_range(0, 7) != 0);
    e.value     = $urandom;
    e.dest_reg  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    e.dest_addr = $urandom;
    e.wr_mem    = ($urandom_range(0, 2) == 0);
    e.mem_size  = MEM_SIZE'($urandom_range(0, 3));
    e.halt      = ($urandom_range(0, 49) == 0);
    return e;
  endfunction

  task automatic step(bit r, ROB_ENTRY e, bit hr, bit mr, bit ma);
    bit x_ret, x_wr, x_req, done;
    bit n_halted, n_error, n_pend, n_acc;
    int n_wait, waited;
    reset = r;
    bus.head_entry = e;
    bus.head_ready = hr;
    bus.mem_ready  = mr;
    bus.mem_ack    = ma;
    @(negedge clock);
    x_ret = 0; x_wr = 0; x_req = 0;
    n_halted = m_halted; n_error = m_error;
    n_pend = m_pend; n_acc = m_acc; n_wait = m_wait;
    if (r || m_halted || m_error) begin
    end else if (!m_pend) begin
      if (e.valid && hr) begin
        if (e.halt) begin
          x_ret = 1; n_halted = 1;
        end else if (e.wr_mem) begin
          n_pend = 1; n_acc = 0; n_wait = 0;
          m_addr = e.dest_addr; m_data = e.value;
          m_size = e.mem_size;
        end else begin
          x_ret = 1; x_wr = (e.dest_reg != 5'd0);
        end
      end
    end else begin
      x_req  = !m_acc;
      waited = m_wait + 1;
      done   = m_acc ? ma : (mr && ma);
      if (done) begin
        x_ret = 1; n_pend = 0;
      end else if (waited == TMO) begin
        n_error = 1; n_pend = 0;
      end else begin
        n_wait = waited;
        if (!m_acc && mr) n_acc = 1;
      end
    end
    chk("rob_retire", 32'(bus.rob_retire), 32'(x_ret));
    chk("reg_wr_en", 32'(bus.reg_wr_en), 32'(x_wr));
    if (x_wr) begin
      chk("reg_wr_idx", 32'(bus.reg_wr_idx), 32'(e.dest_reg));
      chk("reg_wr_data", bus.reg_wr_data, e.value);
    end
    chk("st_req_valid", 32'(bus.st_req_valid), 32'(x_req));
    if (x_req) begin
      chk("st_req_addr", bus.st_req_addr, m_addr);
      chk("st_req_data", bus.st_req_data, m_data);
      chk("st_req_size", 32'(bus.st_req_size), 32'(m_size));
    end
    chk("halted", 32'(halted), 32'(m_halted));
    chk("mem_error", 32'(mem_error), 32'(m_error));
    chk("retire_count", retire_count, m_count);
    if (r) begin
      m_halted = 0; m_error = 0; m_pend = 0; m_acc = 0;
      m_wait = 0; m_addr = '0; m_data = '0; m_size = '0;
      m_count = '0;
    end else begin
      m_halted = n_halted; m_error = n_error;
      m_pend = n_pend; m_acc = n_acc; m_wait = n_wait;
      m_count = m_count + 32'(x_ret);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    ROB_ENTRY nil;
    nil = '0;
    reset = 1'b1;
    bus.head_entry = '0;
    bus.head_ready = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_ack    = 1'b0;

    step(1, nil, 0, 0, 0);
    step(1, nil, 0, 0, 0);
    // ALU retire, zero-reg, not ready, stray ack
    step(0, alu(5'd5, 32'h1234), 1, 0, 0);
    step(0, nil, 0, 0, 0);
    step(0, alu(5'd0, 32'hffff), 1, 0, 0);
    step(0, alu(5'd7, 32'h77), 0, 0, 0);
    step(0, nil, 1, 0, 1);
    // store: ready at +2, ack at +5
    step(0, sto(32'h100, 32'hdeadbeef, WORD), 1, 0, 0);
    step(0, alu(5'd9, $urandom), 1, 0, 0);
    step(0, alu(5'd9, $urandom), 1, 1, 0);
    step(0, alu(5'd9, $urandom), 1, 0, 0);
    step(0, alu(5'd9, $urandom), 1, 0, 0);
    step(0, alu(5'd9, $urandom), 1, 0, 1);
    step(0, nil, 0, 0, 0);
    // ready and ack together
    step(0, sto(32'h2000, 32'h0badf00d, HALF), 1, 0, 0);
    step(0, alu(5'd4, 32'h44), 1, 1, 1);
    step(0, nil, 0, 0, 0);
    // timeout
    step(0, sto(32'h300, 32'h12345678, BYTE), 1, 0, 0);
    step(0, nil, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, alu(5'd2, 32'h2), 1, 0, 0);
    step(0, alu(5'd2, 32'h2), 1, 0, 1);
    step(0, alu(5'd2, 32'h2), 1, 1, 1);
    step(1, nil, 0, 0, 0);
    step(0, nil, 0, 0, 0);
    // halt, then ready heads stay
    step(0, hlt(), 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, alu(5'd6, 32'h66), 1, 0, 0);
    step(1, nil, 0, 0, 0);
    // reset in the middle of a store wait
    step(0, sto(32'h400, 32'hcafe, DOUBLE), 1, 0, 0);
    step(0, nil, 0, 1, 0);
    step(0, nil, 0, 0, 0);
    step(1, alu(5'd8, 32'h88), 1, 0, 1);
    step(0, nil, 0, 0, 1);
    step(0, alu(5'd8, 32'h88), 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) == 0), rnd(),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/commit_ctrl.md
COMMIT_CTRL -- requirements
Module: commit_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles a store may wait in ST_REQ+ST_WAIT before error.
REQ-002 SHALL have port clock  input  1  system clock; single clock domain.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port head_entry  input  ROB_ENTRY  ROB head; uses valid, value, dest_reg, dest_addr, wr_mem, mem_size, halt.
REQ-005 SHALL have port head_ready  input  1  head entry executed and ready to commit.
REQ-006 SHALL have port mem_ready  input  1  data memory accepts store request this cycle.
REQ-007 SHALL have port mem_ack  input  1  data memory reports store completed.
REQ-008 SHALL have port rob_retire  output  1  pop ROB head this cycle.
REQ-009 SHALL have port reg_wr_en / reg_wr_idx / reg_wr_data  output  1/5/32  architectural regfile write.
REQ-010 SHALL have port st_req_valid / st_req_addr / st_req_data / st_req_size  output  1/32/32/MEM_SIZE  store request.
REQ-011 SHALL have port halted, mem_error  output  1 each  sticky status.
REQ-012 SHALL have port retire_count  output  32  committed-instruction counter.

Function
REQ-013 SHALL implement FSM states IDLE, ST_REQ, ST_WAIT, HALTED, ERROR.
REQ-014 IDLE, head valid && head_ready && halt: rob_retire=1 same cycle, next HALTED.
REQ-015 IDLE, head valid && head_ready && wr_mem (not halt): no retire; capture dest_addr, value, mem_size into registers; next ST_REQ.
REQ-016 IDLE, head valid && head_ready, neither halt nor wr_mem: rob_retire=1 same cycle (zero latency); reg_wr_en=1 iff dest_reg != `ZERO_REG, reg_wr_idx=dest_reg, reg_wr_data=value.
REQ-017 IDLE, head not valid or not ready: all strobes 0, stay IDLE.
REQ-018 ST_REQ: st_req_valid=1 driving captured addr/data/size; mem_ready=1 -> ST_WAIT; mem_ready && mem_ack same cycle -> rob_retire=1, next IDLE.
REQ-019 ST_WAIT: st_req_valid=0; mem_ack=1 -> rob_retire=1 same cycle, next IDLE; mem_ack outside ST_REQ/ST_WAIT SHALL be ignored.
REQ-020 head_entry SHALL be ignored in ST_REQ, ST_WAIT, HALTED, ERROR; request fields SHALL use captured values only.
REQ-021 Stores SHALL never assert reg_wr_en.
REQ-022 Timeout counter SHALL clear on entering ST_REQ, increment each cycle in ST_REQ/ST_WAIT; reaching TIMEOUT_CYCLES without completion -> ERROR, no retire.
REQ-023 HALTED and ERROR SHALL be absorbing until reset; rob_retire, reg_wr_en, st_req_valid = 0; halted=1 in HALTED, mem_error=1 in ERROR.
REQ-024 retire_count SHALL increment by 1 each cycle rob_retire=1, wrapping 0xFFFFFFFF -> 0.
REQ-025 At most one retirement per cycle.

Reset
REQ-026 On reset SHALL enter IDLE regardless of state, dropping any pending store without retiring.
REQ-027 Reset values: all strobes 0, halted=0, mem_error=0, retire_count=0, timeout counter 0, captured registers 0.

Structure
REQ-028 ROB_ENTRY, MEM_SIZE, `ZERO_REG SHALL come from shared sys_defs.svh; FSM state enum SHALL be local to commit_ctrl.
REQ-029 No sub-module; commit_ctrl SHALL replace direct instantiation of commit_stage in the top-level pipeline.

Verification
REQ-030 ALU op dest_reg=5, value=0x1234, ready in IDLE -> same cycle rob_retire=1, reg_wr_en=1, idx=5, data=0x1234, retire_count 0->1.
REQ-031 dest_reg=`ZERO_REG ALU op -> rob_retire=1, reg_wr_en=0.
REQ-032 Store addr=0x100, data=0xDEADBEEF; mem_ready at cycle+2, mem_ack at cycle+5 -> st_req_valid held 2 cycles with captured fields, rob_retire=1 exactly at ack cycle, reg_wr_en=0 throughout.
REQ-033 Store with mem_ready && mem_ack in same ST_REQ cycle -> retire that cycle, IDLE next.
REQ-034 TIMEOUT_CYCLES=8, store never acked -> mem_error=1 after 8 cycles, no retire; reset -> IDLE, mem_error=0, retire_count=0.
REQ-035 Halt entry -> one retire, halted=1; later ready heads not retired; reset asserted mid-ST_WAIT -> IDLE, st_req_valid=0, no retire.
